bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock.
- Supports any operand width, a configurable digit count, optional two's-complement input and an overflow flag.
- Uses valid/ready handshakes on both sides so it sits between the multiplier result path and the display/digit drivers without external sequencing.

---
 rtl/bcd_seq.sv | 125 ++++++++++++
 tb/tb_bcd_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one operand bit per clock)
// with valid/ready handshakes on both the operand and the result side.
module bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d, acc_adj;
  logic            ovf_run_q, ovf_run_d;
  logic            neg_q, neg_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            sign_q, sign_d;
  logic            ovf_q, ovf_d;

  // All digits are corrected from their pre-correction values in parallel.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    logic [3:0]    d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = a[4*i +: 4];
      r[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    ovf_run_d = ovf_run_q;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    acc_adj   = add3(acc_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((SIGNED != 0) && binary[WIDTH-1]) begin
            // Most-negative operand negates to 2^(WIDTH-1), which still fits unsigned.
            sr_d  = ~binary + {{(WIDTH-1){1'b0}}, 1'b1};
            neg_d = 1'b1;
          end else begin
            sr_d  = binary;
            neg_d = 1'b0;
          end
          acc_d     = '0;
          ovf_run_d = 1'b0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        acc_d     = {acc_adj[BW-2:0], sr_q[WIDTH-1]};
        sr_d      = {sr_q[WIDTH-2:0], 1'b0};
        ovf_run_d = ovf_run_q | acc_adj[BW-1];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = acc_d;
          sign_d  = neg_q;
          ovf_d   = ovf_run_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      acc_q     <= '0;
      ovf_run_q <= 1'b0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      ovf_run_q <= ovf_run_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_seq.sv
// Bench for bcd_seq: four parameterisations checked against a decimal
// reference model built from integer division and modulo.
module tb_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, ordy = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        iv16 = 1'b0, ordy16 = 1'b0;
  logic [15:0] bin16 = '0;

  logic        ir_a, ov_a, sg_a, of_a;
  logic [11:0] bcd_a;
  logic        ir_b, ov_b, sg_b, of_b;
  logic [11:0] bcd_b;
  logic        ir_c, ov_c, sg_c, of_c;
  logic [7:0]  bcd_c;
  logic        ir_d, ov_d, sg_d, of_d;
  logic [19:0] bcd_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_a), .binary(bin8),
    .out_valid(ov_a), .out_ready(ordy), .bcd(bcd_a), .sign(sg_a), .overflow(of_a));
  bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_b), .binary(bin8),
    .out_valid(ov_b), .out_ready(ordy), .bcd(bcd_b), .sign(sg_b), .overflow(of_b));
  bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_c), .binary(bin8),
    .out_valid(ov_c), .out_ready(ordy), .bcd(bcd_c), .sign(sg_c), .overflow(of_c));
  bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir_d), .binary(bin16),
    .out_valid(ov_d), .out_ready(ordy16), .bcd(bcd_d), .sign(sg_d), .overflow(of_d));

  // Reference: decimal digits of m modulo 10^digits.
  function automatic logic [19:0] dec(input int unsigned m, input int digits);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the three 8-bit instances' held results against the model.
  task automatic check8(input logic [7:0] v);
    int unsigned ma, mb;
    ma = 32'(v);
    mb = v[7] ? 32'd256 - 32'(v) : 32'(v);
    chk("a_bcd",  32'(bcd_a), 32'(dec(ma, 3)));
    chk("a_flags", {30'd0, sg_a, of_a}, 32'd0);
    chk("b_bcd",  32'(bcd_b), 32'(dec(mb, 3)));
    chk("b_sign", 32'(sg_b), 32'(v[7]));
    chk("b_ovf",  32'(of_b), 32'd0);
    chk("c_bcd",  32'(bcd_c), 32'(dec(ma, 2)[7:0]));
    chk("c_ovf",  32'(of_c), 32'(ma >= 100));
    chk("c_sign", 32'(sg_c), 32'd0);
    chk("bc_hs",  {28'd0, ov_b, ov_c, ir_b, ir_c}, 32'hC);
  endtask

  task automatic conv8(input logic [7:0] v);
    int n;
    logic busy_bad;
    n = 0;
    while (!ir_a && n < 50) begin tick(); n++; end
    chk("a_ready_wait", 32'(ir_a), 32'd1);
    iv = 1'b1; bin8 = v;
    tick();
    iv = 1'b0; bin8 = 8'($urandom);
    n = 0; busy_bad = 1'b0;
    while (!ov_a && n < 40) begin
      if (ir_a) busy_bad = 1'b1;
      tick(); n++;
    end
    chk("a_latency", 32'(n), 32'd8);
    chk("a_busy", 32'(busy_bad), 32'd0);
    check8(v);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("a_release", {30'd0, ov_a, ir_a}, 32'd1);
  endtask

  task automatic conv16(input logic [15:0] v);
    int n;
    iv16 = 1'b1; bin16 = v;
    tick();
    iv16 = 1'b0; bin16 = 16'($urandom);
    n = 0;
    while (!ov_d && n < 60) begin tick(); n++; end
    chk("d_latency", 32'(n), 32'd16);
    chk("d_bcd", 32'(bcd_d), 32'(dec(32'(v), 5)));
    chk("d_flags", {30'd0, sg_d, of_d}, 32'd0);
    ordy16 = 1'b1;
    tick();
    ordy16 = 1'b0;
    chk("d_release", {30'd0, ov_d, ir_d}, 32'd1);
  endtask

  initial begin
    logic [11:0] hold;
    logic        bad;
    int          n;

    repeat (3) tick();
    chk("rst_a", {17'd0, ov_a, sg_a, of_a, bcd_a}, 32'd0);
    chk("rst_d", {9'd0, ov_d, sg_d, of_d, bcd_d}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {28'd0, ir_a, ir_b, ir_c, ir_d}, 32'hF);

    // Directed corner operands (unsigned, signed and 2-digit overflow views).
    conv8(8'd255); conv8(8'd0); conv8(8'd100); conv8(8'd99);
    conv8(8'h80);  conv8(8'hFF); conv8(8'h7F);

    // Every operand back to back with in_valid and out_ready held high.
    iv = 1'b1; ordy = 1'b1;
    for (int v = 0; v < 256; v++) begin
      chk("exh_idle", {30'd0, ir_a, ov_a}, 32'd2);
      bin8 = 8'(v);
      tick();
      bad = 1'b0;
      for (int k = 1; k < 8; k++) begin
        tick();
        if (ir_a || ov_a) bad = 1'b1;
      end
      tick();
      chk("exh_busy", 32'(bad), 32'd0);
      chk("exh_done", 32'(ov_a), 32'd1);
      check8(8'(v));
      tick();
    end
    iv = 1'b0; ordy = 1'b0;

    for (int r = 0; r < 6; r++) conv8(8'($urandom));

    conv16(16'd65535); conv16(16'd0);
    for (int r = 0; r < 4; r++) conv16(16'($urandom));

    // Backpressure: result held while out_ready is low and in_valid toggles.
    iv = 1'b1; bin8 = 8'd77;
    tick();
    iv = 1'b0;
    n = 0;
    while (!ov_a && n < 40) begin tick(); n++; end
    hold = bcd_a;
    chk("bp_value", 32'(hold), 32'h077);
    for (int k = 0; k < 5; k++) begin
      iv = 1'($urandom); bin8 = 8'($urandom);
      tick();
      chk("bp_hold", {17'd0, ov_a, ir_a, 1'b0, bcd_a}, {17'd0, 1'b1, 1'b0, 1'b0, hold});
    end
    iv = 1'b0; ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("bp_accept", {18'd0, ov_a, ir_a, bcd_a}, {18'd0, 1'b0, 1'b1, hold});

    // Reset three cycles into a conversion, then a fresh conversion.
    iv = 1'b1; bin8 = 8'd200;
    tick();
    iv = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_a", {17'd0, ov_a, sg_a, of_a, bcd_a}, 32'd0);
    chk("mid_rst_b", {17'd0, ov_b, sg_b, of_b, bcd_b}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    conv8(8'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
